// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbiter client side and the arbiter checker.
package arb_pkg;

  localparam int NCH_DEF        = 4;
  localparam int CNT_W_DEF      = 3;
  localparam int STARVE_LIM_DEF = 15;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PEND = 1'b1
  } chan_state_e;

  // True when at most one bit is set; callers zero-extend vectors up to 32 bits.
  function automatic logic is_onehot0(input logic [31:0] vec);
    return (vec & (vec - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: pending-job counter, held request, completion/drop pulses
// and starvation tracking.
//
//   state   | meaning
//   --------+----------------------------------------------
//   CH_IDLE | cnt == 0, no request to the arbiter
//   CH_PEND | cnt != 0, request held until all jobs consumed
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic job,
  input  logic gvalid,
  output logic req,
  output logic full,
  output logic done,
  output logic drop,
  output logic starve
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       LIM     = 8'(STARVE_LIM);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       wait_q, wait_d;
  logic             starve_q, starve_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             consume;
  chan_state_e      st;

  // The state is fully encoded by the counter, so it is decoded rather than stored.
  assign st      = (cnt_q != '0) ? CH_PEND : CH_IDLE;
  assign req     = (st == CH_PEND);
  assign full    = (cnt_q == CNT_MAX);
  assign consume = gvalid & req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    done_d   = consume;
    drop_d   = 1'b0;

    // A job arriving with a consume cancels out, even when the counter is full.
    if (consume && !job) begin
      cnt_d = cnt_q - 1'b1;
    end else if (job && !consume) begin
      if (full) drop_d = 1'b1;
      else      cnt_d  = cnt_q + 1'b1;
    end

    if (!req || consume)  wait_d = '0;
    else if (wait_q < LIM) wait_d = wait_q + 8'd1;

    if (consume)            starve_d = 1'b0;
    else if (wait_d == LIM) starve_d = 1'b1;
  end

  assign done   = done_q;
  assign drop   = drop_q;
  assign starve = starve_q;

endmodule

// File: rtl/arb_requester.sv
// Client-side front end for the fixed-priority arbiter: per-channel job queues
// feeding held req lines, grant consumption and grant-protocol error detection.
module arb_requester
  import arb_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] job,
  input  logic [NCH-1:0] grant,
  output logic [NCH-1:0] req,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] full,
  output logic [NCH-1:0] drop,
  output logic [NCH-1:0] starve,
  output logic           err
);

  logic [NCH-1:0] gvalid;
  logic           multi;
  logic           stray;
  logic           err_q;

  // A multi-hot grant is discarded entirely; a grant on an idle channel is dropped per bit.
  assign multi  = !is_onehot0(32'(grant));
  assign stray  = |(grant & ~req);
  assign gvalid = multi ? '0 : (grant & req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= multi | stray;
  end

  assign err = err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    arb_req_chan #(
      .CNT_W      (CNT_W),
      .STARVE_LIM (STARVE_LIM)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .job    (job[i]),
      .gvalid (gvalid[i]),
      .req    (req[i]),
      .full   (full[i]),
      .done   (done[i]),
      .drop   (drop[i]),
      .starve (starve[i])
    );
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: reset, single job, overflow, back-to-back,
// starvation and grant-protocol errors.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] job;
  logic [3:0] grant;
  logic [3:0] req, done, full, drop, starve;
  logic       err;

  int errors = 0;
  int checks = 0;

  arb_requester dut (
    .clk    (clk),
    .rst    (rst),
    .job    (job),
    .grant  (grant),
    .req    (req),
    .done   (done),
    .full   (full),
    .drop   (drop),
    .starve (starve),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; job = '0; grant = '0;
    #3;
    checks++;
    if ({req, done, full, drop, starve, err} !== 21'd0) begin
      errors++; $display("FAIL reset_state outputs=%h expected 0", {req, done, full, drop, starve, err});
    end
    tick(); rst = 1'b1;
    job = 4'b0001;
    tick(); tick(); tick();
    job = '0;
    checks++;
    if (req !== 4'b0001) begin errors++; $display("FAIL reset_preload req=%b expected 0001", req); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (req !== 4'b0000) begin errors++; $display("FAIL reset_async req=%b expected 0000", req); end
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (req !== 4'b0000 || done !== 4'b0000) begin
      errors++; $display("FAIL reset_release req=%b done=%b expected 0000/0000", req, done);
    end
  endtask

  task automatic test_single();
    job = 4'b0001;
    tick();
    job = '0;
    checks++;
    if (req !== 4'b0001 || done !== 4'b0000) begin
      errors++; $display("FAIL single_req req=%b done=%b expected 0001/0000", req, done);
    end
    grant = 4'b0001;
    tick();
    grant = '0;
    checks++;
    if (done !== 4'b0001 || req !== 4'b0000 || err !== 1'b0) begin
      errors++; $display("FAIL single_done done=%b req=%b err=%b expected 0001/0000/0", done, req, err);
    end
    tick();
    checks++;
    if (done !== 4'b0000) begin errors++; $display("FAIL single_done_width done=%b expected 0000", done); end
  endtask

  task automatic test_overflow();
    job = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (drop !== ((k == 8) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL overflow_drop pulse=%0d drop=%b", k, drop);
      end
    end
    job = '0;
    checks++;
    if (full !== 4'b0100 || req !== 4'b0100) begin
      errors++; $display("FAIL overflow_full full=%b req=%b expected 0100/0100", full, req);
    end
    tick();
    checks++;
    if (drop !== 4'b0000 || full !== 4'b0100) begin
      errors++; $display("FAIL overflow_drop_width drop=%b full=%b expected 0000/0100", drop, full);
    end
    job = 4'b0100; grant = 4'b0100;
    tick();
    job = '0; grant = '0;
    checks++;
    if (done !== 4'b0100 || drop !== 4'b0000 || full !== 4'b0100) begin
      errors++; $display("FAIL overflow_job_and_grant done=%b drop=%b full=%b expected 0100/0000/0100", done, drop, full);
    end
    grant = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (done !== 4'b0100 || full !== 4'b0000) begin
        errors++; $display("FAIL overflow_drain step=%0d done=%b full=%b expected 0100/0000", k, done, full);
      end
    end
    grant = '0;
    checks++;
    if (req !== 4'b0000 || starve !== 4'b0000) begin
      errors++; $display("FAIL overflow_empty req=%b starve=%b expected 0000/0000", req, starve);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    job = 4'b0010;
    tick(); tick(); tick();
    job = '0;
    grant = 4'b0010;
    tick();
    checks++;
    if (done !== 4'b0010 || req !== 4'b0010) begin
      errors++; $display("FAIL b2b_1 done=%b req=%b expected 0010/0010", done, req);
    end
    tick();
    checks++;
    if (done !== 4'b0010 || req !== 4'b0010) begin
      errors++; $display("FAIL b2b_2 done=%b req=%b expected 0010/0010", done, req);
    end
    tick();
    grant = '0;
    checks++;
    if (done !== 4'b0010 || req !== 4'b0000) begin
      errors++; $display("FAIL b2b_3 done=%b req=%b expected 0010/0000", done, req);
    end
    tick();
    checks++;
    if (done !== 4'b0000 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_end done=%b err=%b expected 0000/0", done, err);
    end
  endtask

  task automatic test_starve();
    // Two jobs: req rises after the first edge, so the second edge is already a wait cycle.
    job = 4'b1000;
    tick(); tick();
    job = '0;
    for (int k = 0; k < 13; k++) tick();
    checks++;
    if (starve !== 4'b0000) begin errors++; $display("FAIL starve_early starve=%b expected 0000", starve); end
    tick();
    checks++;
    if (starve !== 4'b1000) begin errors++; $display("FAIL starve_rise starve=%b expected 1000", starve); end
    tick(); tick(); tick();
    checks++;
    if (starve !== 4'b1000) begin errors++; $display("FAIL starve_sticky starve=%b expected 1000", starve); end
    grant = 4'b1000;
    tick();
    grant = '0;
    checks++;
    if (starve !== 4'b0000 || done !== 4'b1000 || req !== 4'b1000) begin
      errors++; $display("FAIL starve_clear starve=%b done=%b req=%b expected 0000/1000/1000", starve, done, req);
    end
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if (starve !== 4'b0000) begin errors++; $display("FAIL starve_wait_reset starve=%b expected 0000", starve); end
    tick();
    checks++;
    if (starve !== 4'b1000) begin errors++; $display("FAIL starve_rerise starve=%b expected 1000", starve); end
    grant = 4'b1000;
    tick();
    grant = '0;
    checks++;
    if (starve !== 4'b0000 || req !== 4'b0000) begin
      errors++; $display("FAIL starve_drain starve=%b req=%b expected 0000/0000", starve, req);
    end
    tick();
  endtask

  task automatic test_protocol();
    job = 4'b0011;
    tick();
    job = '0;
    grant = 4'b0011;
    tick();
    grant = '0;
    checks++;
    if (err !== 1'b1 || done !== 4'b0000 || req !== 4'b0011) begin
      errors++; $display("FAIL proto_multi err=%b done=%b req=%b expected 1/0000/0011", err, done, req);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL proto_err_width err=%b expected 0", err); end
    grant = 4'b0010;
    tick();
    grant = '0;
    checks++;
    if (done !== 4'b0010 || req !== 4'b0001 || err !== 1'b0) begin
      errors++; $display("FAIL proto_count_kept done=%b req=%b err=%b expected 0010/0001/0", done, req, err);
    end
    grant = 4'b0100;
    tick();
    grant = '0;
    checks++;
    if (err !== 1'b1 || done !== 4'b0000 || req !== 4'b0001) begin
      errors++; $display("FAIL proto_stray err=%b done=%b req=%b expected 1/0000/0001", err, done, req);
    end
    grant = 4'b0110;
    tick();
    grant = '0;
    checks++;
    if (err !== 1'b1 || done !== 4'b0000) begin
      errors++; $display("FAIL proto_both err=%b done=%b expected 1/0000", err, done);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL proto_both_single err=%b expected 0", err); end
    grant = 4'b0001;
    tick();
    grant = '0;
    checks++;
    if (done !== 4'b0001 || req !== 4'b0000 || err !== 1'b0) begin
      errors++; $display("FAIL proto_final done=%b req=%b err=%b expected 0001/0000/0", done, req, err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_starve();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
